// File: rtl/mult_control.sv
// Sequencer for a nibble-serial 8x8 multiplier: steps a 4x4 multiplier, shifter and
// 16-bit accumulator through the four partial products and flags the finished result.
module mult_control (
    input  logic       clk,
    input  logic       sclr,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       busy,
    output logic       done_flag,
    output logic       err,
    output logic [2:0] state_out
);

    // start is a one-cycle request; it is accepted in IDLE or DONE, and seeing it
    // anywhere inside the CLR..MSB sequence is a protocol violation that lands in ERR.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_CLR  = 3'b001,
        S_LSB  = 3'b010,
        S_MID  = 3'b011,
        S_MSB  = 3'b100,
        S_DONE = 3'b101,
        S_ERR  = 3'b110
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                cnt_d   = 2'd0;
                state_d = start ? S_ERR : S_LSB;
            end
            S_LSB: begin
                cnt_d   = start ? 2'd0 : 2'd1;
                state_d = start ? S_ERR : S_MID;
            end
            S_MID: begin
                // MID spans two cycles: cnt=1 (A lo x B hi) then cnt=2 (A hi x B lo)
                if (start) begin
                    cnt_d   = 2'd0;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd1) ? S_MID : S_MSB;
                end
            end
            S_MSB: begin
                cnt_d   = 2'd0;
                state_d = start ? S_ERR : S_DONE;
            end
            S_DONE: begin
                cnt_d   = 2'd0;
                state_d = start ? S_CLR : S_IDLE;
            end
            S_ERR: begin
                cnt_d   = 2'd0;
                state_d = start ? S_ERR : S_IDLE;
            end
            default: begin
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        input_sel = 2'b00;
        shift_sel = 2'b00;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        busy      = 1'b0;
        done_flag = 1'b0;
        err       = 1'b0;
        state_out = 3'b000;
        case (state_q)
            S_IDLE: begin
                state_out = 3'b000;
            end
            S_CLR: begin
                clk_ena   = 1'b1;
                sclr_n    = 1'b0;
                busy      = 1'b1;
                state_out = 3'b001;
            end
            S_LSB: begin
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b010;
            end
            S_MID: begin
                input_sel = (cnt_q == 2'd1) ? 2'b01 : 2'b10;
                shift_sel = 2'b01;
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b011;
            end
            S_MSB: begin
                input_sel = 2'b11;
                shift_sel = 2'b10;
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b100;
            end
            S_DONE: begin
                done_flag = 1'b1;
                state_out = 3'b101;
            end
            S_ERR: begin
                err       = 1'b1;
                state_out = 3'b110;
            end
            default: begin
                state_out = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: wraps it with a behavioural nibble datapath and checks
// products through a scoreboard plus per-cycle control sequences against fixed tables.
module tb_mult_control;

    logic       clk;
    logic       sclr;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       busy;
    logic       done_flag;
    logic       err;
    logic [2:0] state_out;

    logic [7:0]  op_a, op_b;
    logic [15:0] acc;
    logic [15:0] pp;
    logic [3:0]  a_nib, b_nib;

    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // expected control sequence for one multiply, starting in the cycle after start
    logic [2:0] exp_st  [6] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b101};
    logic [1:0] exp_isel[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] exp_ssel[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic       exp_ena [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_sn  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_busy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mult_control dut (
        .clk       (clk),
        .sclr      (sclr),
        .start     (start),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .busy      (busy),
        .done_flag (done_flag),
        .err       (err),
        .state_out (state_out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath harness: 4x4 multiplier, shifter, adder, 16-bit register
    always_comb begin
        a_nib = input_sel[1] ? op_a[7:4] : op_a[3:0];
        b_nib = input_sel[0] ? op_b[7:4] : op_b[3:0];
        pp    = 16'(a_nib) * 16'(b_nib);
        case (shift_sel)
            2'b01:   pp = pp << 4;
            2'b10:   pp = pp << 8;
            default: pp = pp;
        endcase
    end

    always @(posedge clk) begin
        if (!sclr_n)      acc <= 16'h0000;
        else if (clk_ena) acc <= acc + pp;
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // monitor: every done_flag cycle must match the oldest outstanding product
    always @(negedge clk) begin
        if (done_flag) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("product", acc, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issues start and walks the six cycles up to DONE; returns while in DONE
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back({8'h00, a} * {8'h00, b});
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk("seq_state",  state_out, exp_st[i]);
            chk("seq_isel",   input_sel, exp_isel[i]);
            chk("seq_ssel",   shift_sel, exp_ssel[i]);
            chk("seq_clkena", clk_ena,   exp_ena[i]);
            chk("seq_sclrn",  sclr_n,    exp_sn[i]);
            chk("seq_busy",   busy,      exp_busy[i]);
            chk("seq_done",   done_flag, (i == 5) ? 1 : 0);
            chk("seq_err",    err,       0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"},  state_out, 0);
        chk({tag, "_isel"},   input_sel, 0);
        chk({tag, "_ssel"},   shift_sel, 0);
        chk({tag, "_clkena"}, clk_ena,   0);
        chk({tag, "_sclrn"},  sclr_n,    1);
        chk({tag, "_busy"},   busy,      0);
        chk({tag, "_done"},   done_flag, 0);
        chk({tag, "_err"},    err,       0);
    endtask

    initial begin
        sclr  = 1'b1;
        start = 1'b1;
        op_a  = 8'h00;
        op_b  = 8'h00;
        tick();
        chk_idle("rst1");
        tick();
        chk_idle("rst2");
        sclr  = 1'b0;
        start = 1'b0;
        tick();
        chk_idle("post_rst");

        // full-scale operands, then back-to-back multiply started from DONE
        run_mult(8'hFF, 8'hFF);
        chk("ff_acc", acc, 16'hFE01);
        run_mult(8'h12, 8'h34);
        chk("b2b_acc", acc, 16'h03A8);
        tick();
        chk_idle("after_b2b");
        tick();
        chk("hold_acc", acc, 16'h03A8);

        run_mult(8'h00, 8'hAB);
        chk("zero_acc", acc, 16'h0000);
        tick();

        // start re-pulsed in MID, then held
        op_a  = 8'h5A;
        op_b  = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_err_state", state_out, 3'b011);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_state",  state_out, 3'b110);
            chk("err_flag",   err,       1);
            chk("err_clkena", clk_ena,   0);
            chk("err_busy",   busy,      0);
        end
        start = 1'b0;
        tick();
        chk_idle("err_exit");

        // start seen in CLR is also an error
        start = 1'b1;
        tick();
        tick();
        chk("clr_err_state", state_out, 3'b110);
        start = 1'b0;
        tick();
        chk_idle("clr_err_exit");

        // synchronous reset in MID abandons the multiply
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk_idle("mid_rst");
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst_done", done_flag, 0);
        run_mult(8'h9D, 8'h47);
        tick();

        // randomized operands with random gaps or back-to-back starts
        for (int r = 0; r < 30; r++) begin
            run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk("gap_state", state_out, 0);
                for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            end
        end
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
